// File: rtl/seq_wide_adder_ctrl.sv
// Sequential WIDTH-bit add/subtract controller built on one shared 8-bit
// hybrid adder, one slice per clock, LSB first, with a registered carry chain.

module hybrid (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Lookahead inside each nibble, ripple between the two nibbles
    function automatic logic [3:0] cla4(
        input logic [3:0] gg,
        input logic [3:0] pp,
        input logic       ci
    );
        logic [3:0] co;
        co[0] = gg[0] | (pp[0] & ci);
        co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & ci);
        co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
              | (pp[3] & pp[2] & pp[1] & gg[0])
              | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
        return co;
    endfunction

    always_comb begin
        g      = a & b;
        p      = a ^ b;
        c[0]   = c_in;
        c[4:1] = cla4(g[3:0], p[3:0], c[0]);
        c[8:5] = cla4(g[7:4], p[7:4], c[4]);
        sum    = p ^ c[7:0];
        c_out  = c[8];
    end

endmodule

module seq_wide_adder_ctrl #(
    parameter int NSLICES = 4,
    parameter int WIDTH   = 8 * NSLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int IW = $clog2(NSLICES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_next;

    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_sum;
    logic       add_co;

    // Adder is fed purely from registered state
    assign add_a = a_q[idx*8 +: 8];
    assign add_b = b_q[idx*8 +: 8];

    hybrid u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_q),
        .sum   (add_sum),
        .c_out (add_co)
    );

    always_comb begin
        work_next = work_q;
        work_next[idx*8 +: 8] = add_sum;
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                (state == RUN): begin
                    work_q  <= work_next;
                    carry_q <= add_co;
                    idx     <= idx + IW'(1);
                    if (idx == LAST) begin
                        idx    <= '0;
                        state  <= DONE;
                        result <= work_next;
                        c_out  <= add_co;
                        ovf    <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                                  && (add_sum[7] != a_q[WIDTH-1]);
                    end
                end
                (state == DONE): begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_wide_adder_ctrl.md
Name: seq_wide_adder_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing one internal 8-bit `hybrid` adder instance (ports a, b, c_in, c_out, sum).
- Processes one 8-bit slice per clock, LSB slice first, and chains the carry through a register.
- Uses a start/ready/done handshake and sits between the register file/ALU issue logic and the adder datapath.

Parameters:
- NSLICES, 4, number of 8-bit slices per operation; WIDTH = 8*NSLICES; legal range 2..8.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- sub  in  1  1 = op_a - op_b, 0 = op_a + op_b + c_in; sampled with start.
- c_in  in  1  carry-in for add; ignored when sub=1; sampled with start.
- op_a  in  WIDTH  operand A; sampled with start.
- op_b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last completed sum/difference.
- c_out  out  1  carry out of MSB slice (sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow of last operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, slice index=0, carry register=0, working registers=0.
  - result=0, c_out=0, ovf=0, done=0, busy=0, ready=1 (ready follows IDLE).
- States: IDLE, RUN, DONE.
  - IDLE: on an edge with start=1, latch op_a, op_b_eff, carry0; idx<=0; go to RUN.
    - op_b_eff = sub ? ~op_b : op_b.
    - carry0 = sub ? 1 : c_in.
  - RUN: each edge:
    - adder.a = A[idx*8+:8], adder.b = B_eff[idx*8+:8], adder.c_in = carry register.
    - Write adder.sum into work[idx*8+:8]; carry register <= adder.c_out; idx <= idx+1.
    - On the edge processing idx=NSLICES-1, go to DONE and, in the same edge:
      - result <= completed work value.
      - c_out <= adder.c_out.
      - ovf <= (A[MSB]==B_eff[MSB]) && (final sum MSB != A[MSB]).
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E0; slices computed at edges E1..E(NSLICES); done high between E(NSLICES) and E(NSLICES+1). With NSLICES=4, done is high in the 5th cycle after start is sampled.
- Throughput: one operation per NSLICES+2 cycles. start in RUN or DONE is ignored, not queued.
- Operand stability: inputs are sampled only at acceptance. Changes to op_a/op_b/sub/c_in during RUN have no effect.
- result/c_out/ovf:
  - Update only at the final RUN edge; partial slices are never visible on result.
  - Hold until the next operation completes.
- Adder inputs: driven from registered state only (no combinational path from start/op_* to the adder). Inputs are don't-care outside RUN but must be driven, no X.
- Reset mid-operation: immediate return to reset values; done never pulses for the aborted operation; result returns to 0.
- Width: all arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset: hold rst_n=0 mid-cycle, release -> ready=1, busy=0, done=0, result=0x00000000, c_out=0, ovf=0.
- Add with carry-in: op_a=0x00000010, op_b=0x00000005, c_in=1, sub=0 -> done in 5th cycle after start, result=0x00000016, c_out=0, ovf=0; busy high exactly 4 cycles.
- Full carry ripple: op_a=0xFFFFFFFF, op_b=0x00000001, c_in=0 -> result=0x00000000, c_out=1, ovf=0.
- Signed overflow: op_a=0x7FFFFFFF, op_b=0x00000001, c_in=0 -> result=0x80000000, c_out=0, ovf=1.
- Subtract with borrow: op_a=0x00000005, op_b=0x00000010, sub=1, c_in=1 (ignored) -> result=0xFFFFFFF5, c_out=0, ovf=0. Also op_a=0x80000000, op_b=0x00000001, sub=1 -> result=0x7FFFFFFF, c_out=1, ovf=1.
- Busy/abort:
  - Pulse start again during RUN with different operands -> ignored; first result delivered unchanged.
  - Then start a new operation and drop rst_n during its 2nd RUN cycle -> immediate IDLE, result=0, no done pulse.
